// File: rtl/branch_resolve_pc.sv
// branch_resolve_pc: branch resolution, PC sequencing and wrong-path flush timing.
// Define BRANCH_CNT_EN to add the saturating 16-bit branch_count output.
module branch_resolve_pc #(
    parameter int FLAGS_W      = 8,
    parameter int PC_W         = 10,
    parameter int PC_MAX       = 1023,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [FLAGS_W-1:0] im_flags,
    input  logic [PC_W-1:0]    baddr_in,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic [PC_W-1:0]    pc_out,
    output logic               branch_taken,
    output logic               flush
`ifdef BRANCH_CNT_EN
    ,
    output logic [15:0]        branch_count
`endif
);
    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [PC_W-1:0]   pc_n, pc_inc;
    logic              taken_n, flush_n, take;

    assign take   = (state == ST_RUN) && |(im_flags & alu_flags);
    assign pc_inc = (pc_out == PC_W'(PC_MAX)) ? '0 : pc_out + PC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            cnt          <= '0;
            pc_out       <= PC_W'(RESET_PC);
            branch_taken <= 1'b0;
            flush        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pc_out       <= pc_n;
            branch_taken <= taken_n;
            flush        <= flush_n;
        end
    end

    // With enable low every default holds, which also stretches a taken pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc_out;
        taken_n = branch_taken;
        flush_n = flush;
        if (enable) begin
            taken_n = 1'b0;
            pc_n    = pc_inc;
            if (state == ST_RUN) begin
                flush_n = take;
                if (take) begin
                    pc_n    = baddr_in;
                    taken_n = 1'b1;
                    cnt_n   = 4'(FLUSH_CYCLES - 1);
                    state_n = ST_FLUSH;
                end
            end else if (cnt == 4'd0) begin
                flush_n = 1'b0;
                state_n = ST_RUN;
            end else begin
                cnt_n = cnt - 4'd1;
            end
        end
    end

`ifdef BRANCH_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            branch_count <= '0;
        else if (enable && take && branch_count != 16'hFFFF)
            branch_count <= branch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_branch_resolve_pc.sv
// tb_branch_resolve_pc: directed vector table plus stall and counter sequences.
module tb_branch_resolve_pc;
    logic       clk = 1'b0;
    logic       reset, enable;
    logic [7:0] im_flags, alu_flags;
    logic [9:0] baddr_in, pc_out;
    logic       branch_taken, flush;
`ifdef BRANCH_CNT_EN
    logic [15:0] branch_count;
`endif

    branch_resolve_pc dut (
        .clk(clk), .reset(reset), .enable(enable), .im_flags(im_flags),
        .baddr_in(baddr_in), .alu_flags(alu_flags), .pc_out(pc_out),
        .branch_taken(branch_taken), .flush(flush)
`ifdef BRANCH_CNT_EN
        , .branch_count(branch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en;
        logic [7:0] im, alu;
        logic [9:0] ba, pc;
        logic       bt, fl;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic add(input logic r, input logic e, input logic [7:0] im, input logic [7:0] alu,
                       input logic [9:0] ba, input logic [9:0] pc, input logic bt, input logic fl);
        vq.push_back('{r, e, im, alu, ba, pc, bt, fl});
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] im, input logic [7:0] alu,
                        input logic [9:0] ba);
        reset = r; enable = e; im_flags = im; alu_flags = alu; baddr_in = ba;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int flush_en, cyc;
        reset = 1'b1; enable = 1'b1; im_flags = '0; alu_flags = '0; baddr_in = '0;
        // rst en im alu ba -> pc bt fl
        add(1, 1, 8'h00, 8'h00, 10'h000, 10'h000, 0, 0);
        add(1, 1, 8'h00, 8'h00, 10'h000, 10'h000, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 8'h00, 8'h00, 10'h000, 10'(i), 0, 0);
        add(0, 1, 8'h01, 8'h01, 10'h100, 10'h100, 1, 1);
        add(0, 1, 8'h01, 8'hFF, 10'h020, 10'h101, 0, 1);
        add(0, 1, 8'h01, 8'hFF, 10'h020, 10'h102, 0, 1);
        add(0, 1, 8'h01, 8'hFF, 10'h020, 10'h103, 0, 1);
        add(0, 1, 8'h01, 8'hFF, 10'h020, 10'h104, 0, 0);
        add(0, 1, 8'h04, 8'h03, 10'h020, 10'h105, 0, 0);
        add(0, 1, 8'h00, 8'hFF, 10'h020, 10'h106, 0, 0);
        add(0, 1, 8'hFF, 8'h00, 10'h020, 10'h107, 0, 0);
        add(0, 1, 8'h80, 8'h80, 10'h3FF, 10'h3FF, 1, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h000, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h001, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h002, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h003, 0, 0);
        add(0, 1, 8'h02, 8'h02, 10'h003, 10'h003, 1, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h004, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h005, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h006, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h007, 0, 0);
        add(0, 1, 8'h01, 8'h01, 10'h050, 10'h050, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 8'h00, 10'h000, 10'h050, 1, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h051, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h052, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h053, 0, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h054, 0, 0);
        add(0, 1, 8'h01, 8'h01, 10'h200, 10'h200, 1, 1);
        add(0, 1, 8'h00, 8'h00, 10'h000, 10'h201, 0, 1);
        add(1, 0, 8'h00, 8'h00, 10'h000, 10'h000, 0, 0);
        add(0, 1, 8'h01, 8'h01, 10'h010, 10'h010, 1, 1);
        for (int i = 1; i <= 4; i++) add(0, 1, 8'h00, 8'h00, 10'h000, 10'(16 + i), 0, i < 4);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].im, vq[i].alu, vq[i].ba);
            check("pc_out", i, 16'(pc_out), 16'(vq[i].pc));
            check("branch_taken", i, 16'(branch_taken), 16'(vq[i].bt));
            check("flush", i, 16'(flush), 16'(vq[i].fl));
        end

        // Branch, then toggle enable and count enabled cycles with flush high.
        step(0, 1, 8'h01, 8'h01, 10'h080);
        flush_en = flush ? 1 : 0;
        cyc = 0;
        while (flush && cyc < 40) begin
            step(0, cyc % 2 == 1, 8'h00, 8'h00, 10'h000);
            if (enable && flush) flush_en++;
            cyc++;
        end
        check("flush_enabled_cycles", 0, 16'(flush_en), 16'd4);
        check("pc_after_stalled_flush", 0, 16'(pc_out), 16'h084);

`ifdef BRANCH_CNT_EN
        step(1, 1, 8'h00, 8'h00, 10'h000);
        check("branch_count_reset", 0, branch_count, 16'd0);
        for (int b = 0; b < 5; b++) begin
            step(0, 1, 8'h01, 8'h01, 10'(b * 32));
            for (int k = 0; k < 4; k++) step(0, 1, 8'h01, 8'h01, 10'h000);
        end
        check("branch_count_five", 0, branch_count, 16'd5);
        step(0, 0, 8'h01, 8'h01, 10'h000);
        check("branch_count_stall", 0, branch_count, 16'd5);
        step(1, 1, 8'h00, 8'h00, 10'h000);
        check("branch_count_clear", 0, branch_count, 16'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
